// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the writeback slice.
//   - load funct3 encodings (LB, LH, LW, LBU, LHU)
//   - default datapath width
//   - alignment masks and a helper that decides whether a load is misaligned
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_e;

    // Offset bits that must be zero for an access of the given size.
    localparam logic [1:0] HALF_ALIGN_MASK = 2'b01;
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    function automatic logic load_misaligned(input logic [2:0] funct3,
                                             input logic [1:0] byte_off);
        logic mis;
        mis = 1'b0;
        case (funct3)
            LH, LHU: mis = |(byte_off & HALF_ALIGN_MASK);
            LW:      mis = |(byte_off & WORD_ALIGN_MASK);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// load_formatter: combinational load-data alignment and sign/zero extension.
// Ports:
//   raw_i       XLEN  raw memory read word (only bits [31:0] feed sub-word loads)
//   funct3_i    3     load size/sign code
//   byte_off_i  2     load address bits [1:0]
//   data_o      XLEN  formatted load data
//   misalign_o  1     access is not naturally aligned
module load_formatter
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] raw_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      byte_off_i,
    output logic [XLEN-1:0] data_o,
    output logic            misalign_o
);

    logic [31:0] word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign word = raw_i[31:0];

    always_comb begin
        byte_sel = word[7:0];
        case (byte_off_i)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        // Halfword picks by off[1] only; off[0] is reported as misalignment.
        half_sel = byte_off_i[1] ? word[31:16] : word[15:0];

        data_o     = raw_i;
        misalign_o = 1'b0;
        case (funct3_i)
            LB:  data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LBU: data_o = {{(XLEN-8){1'b0}}, byte_sel};
            LH:  data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            LHU: data_o = {{(XLEN-16){1'b0}}, half_sel};
            LW:  data_o = {{(XLEN-32){word[31]}}, word};
            default: data_o = raw_i;
        endcase
        misalign_o = load_misaligned(funct3_i, byte_off_i);
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register with N-way result select and load formatting.
// Ports:
//   clk_i, rst_ni           clock (rising edge), asynchronous active-low reset
//   valid_i, stall_i, flush_i  MEM-stage valid and hazard-unit controls
//   src_data_i              NUM_SRC packed result sources, source k at [k*XLEN +: XLEN]
//   wb_sel_i                result source select (out-of-range selects give 0)
//   reg_write_i, rd_addr_i  register write request and destination
//   funct3_i, byte_off_i    load size/sign code and address bits [1:0]
//   wb_valid_o, wb_we_o, wb_rd_o, wb_data_o  registered register-file write port
//   misalign_o              registered misaligned-load flag
//   instret_o               64-bit retired-instruction counter
// All outputs come directly from flops.
module wb_stage
    import riscv_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NUM_SRC  = 4,
    parameter int SEL_W    = $clog2(NUM_SRC),
    parameter int LOAD_SRC = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    valid_i,
    input  logic                    stall_i,
    input  logic                    flush_i,
    input  logic [NUM_SRC*XLEN-1:0] src_data_i,
    input  logic [SEL_W-1:0]        wb_sel_i,
    input  logic                    reg_write_i,
    input  logic [4:0]              rd_addr_i,
    input  logic [2:0]              funct3_i,
    input  logic [1:0]              byte_off_i,
    output logic                    wb_valid_o,
    output logic                    wb_we_o,
    output logic [4:0]              wb_rd_o,
    output logic [XLEN-1:0]         wb_data_o,
    output logic                    misalign_o,
    output logic [63:0]             instret_o
);

    logic [XLEN-1:0] src_arr [NUM_SRC];
    logic [XLEN-1:0] sel_data;
    logic [XLEN-1:0] fmt_data;
    logic            fmt_misalign;
    logic            is_load;

    logic [XLEN-1:0] data_next;
    logic            misalign_next;
    logic            we_next;

    logic            valid_reg;
    logic            we_reg;
    logic [4:0]      rd_reg;
    logic [XLEN-1:0] data_reg;
    logic            misalign_reg;
    logic [63:0]     instret_reg;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
        assign src_arr[gi] = src_data_i[gi*XLEN +: XLEN];
    end

    // Compare against each legal index; a select with no match leaves zero.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (wb_sel_i == SEL_W'(k)) begin
                sel_data = src_arr[k];
            end
        end
    end

    assign is_load = (wb_sel_i == SEL_W'(LOAD_SRC));

    load_formatter #(
        .XLEN (XLEN)
    ) u_load_formatter (
        .raw_i      (src_arr[LOAD_SRC]),
        .funct3_i   (funct3_i),
        .byte_off_i (byte_off_i),
        .data_o     (fmt_data),
        .misalign_o (fmt_misalign)
    );

    assign data_next     = is_load ? fmt_data : sel_data;
    // Gated by valid_i so a bubble never carries a misalign flag.
    assign misalign_next = valid_i & is_load & fmt_misalign;
    // Write enable is resolved before the register so wb_we_o is a plain flop.
    assign we_next       = valid_i & reg_write_i & (rd_addr_i != 5'd0) & ~misalign_next;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_reg    <= 1'b0;
            we_reg       <= 1'b0;
            rd_reg       <= '0;
            data_reg     <= '0;
            misalign_reg <= 1'b0;
        end else if (flush_i) begin
            // Bubble: data and rd keep their last value, qualifiers drop.
            valid_reg    <= 1'b0;
            we_reg       <= 1'b0;
            misalign_reg <= 1'b0;
        end else if (!stall_i) begin
            valid_reg    <= valid_i;
            we_reg       <= we_next;
            rd_reg       <= rd_addr_i;
            data_reg     <= data_next;
            misalign_reg <= misalign_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instret_reg <= '0;
        end else if (valid_i && !stall_i && !flush_i) begin
            instret_reg <= instret_reg + 64'd1;
        end
    end

    assign wb_valid_o = valid_reg;
    assign wb_we_o    = we_reg;
    assign wb_rd_o    = rd_reg;
    assign wb_data_o  = data_reg;
    assign misalign_o = misalign_reg;
    assign instret_o  = instret_reg;

endmodule
